serializer_tx_sched: RTL

- Round-robin scheduler that shares one downstream serializer (MSB-first, fires when its counter input equals MSG_SIZE) between N_REQ message sources.
- The serializer's done state is sticky until its reset, so this block re-arms it with a one-cycle local reset before every message.
- Per message it latches the winner's data, drives the counter to MSG_SIZE, watches the serial valid flag, then acks the requester.
- Sits between the crypto/message producers and the serializer at the chip's serial output.

---
 rtl/serializer_tx_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/serializer_tx_sched.sv
// Round-robin scheduler that shares one MSB-first serializer between N_REQ message sources.
// Latency: grant to ack is MSG_SIZE+4 cycles with ena held high and a serializer that raises its flag one cycle after arming.
// Backpressure: req is a level held until ack; ena=0 freezes ARM/RUN, and a stuck or short flag ends in an err pulse.
module serializer_tx_sched #(
  parameter int MSG_SIZE    = 64,
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 2*MSG_SIZE+8,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW = $clog2(MSG_SIZE) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*MSG_SIZE-1:0] data_in,
  output logic [N_REQ-1:0]          ack,
  output logic                      err,
  output logic                      busy,
  output logic [GW-1:0]             grant_id,
  output logic [MSG_SIZE-1:0]       ser_data,
  output logic [CW-1:0]             ser_counter,
  output logic                      ser_rst_n,
  input  logic                      ser_flag
);

  // Timer must be able to hold TIMEOUT_CYC; len gets one spare bit and saturates,
  // so a flag stuck high can never wrap back onto MSG_SIZE.
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(MSG_SIZE + 1) + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(MSG_SIZE);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] LEN_FULL = LW'(MSG_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REARM,
    S_ARM,
    S_RUN,
    S_ACK,
    S_ABORT
  } state_t;

  state_t         state;
  logic [GW-1:0]  rr_ptr;
  logic [TW-1:0]  timer;
  logic [LW-1:0]  len;

  logic [GW-1:0]  pick;
  logic [GW-1:0]  pick_next;
  logic           pick_vld;

  // Round-robin search: first set req at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_vld && req[(int'(rr_ptr) + i) % N_REQ]) begin
        pick_vld = 1'b1;
        pick     = GW'((int'(rr_ptr) + i) % N_REQ);
      end
    end
  end

  // Priority pointer moves one past the winner so a continuous requester cannot win twice in a row.
  always_comb begin
    pick_next = '0;
    if (int'(pick) != N_REQ - 1) begin
      pick_next = pick + 1'b1;
    end
  end

  // Message sequencer; every output is registered and updated on entry to the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      timer       <= '0;
      len         <= '0;
      ack         <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= '0;
      ser_data    <= '0;
      ser_counter <= '0;
      ser_rst_n   <= 1'b1;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ena && pick_vld) begin
            state       <= S_REARM;
            grant_id    <= pick;
            ser_data    <= data_in[int'(pick)*MSG_SIZE +: MSG_SIZE];
            rr_ptr      <= pick_next;
            busy        <= 1'b1;
            ser_rst_n   <= 1'b0;
            ser_counter <= '0;
            timer       <= '0;
            len         <= '0;
          end
        end

        // One-cycle local reset clears the serializer's sticky done before arming it.
        S_REARM: begin
          state       <= S_ARM;
          ser_rst_n   <= 1'b1;
          ser_counter <= CNT_FULL;
        end

        // Armed and waiting for the first valid bit; frozen while ena is low.
        S_ARM: begin
          if (ena) begin
            if (timer == TMO_LAST) begin
              state       <= S_ABORT;
              err         <= 1'b1;
              ser_rst_n   <= 1'b0;
              ser_counter <= '0;
              timer       <= '0;
            end else begin
              timer <= timer + 1'b1;
              if (ser_flag) begin
                state <= S_RUN;
                len   <= LW'(1);
              end
            end
          end
        end

        // Count flag-high cycles; the falling flag ends the message and its length is judged then.
        S_RUN: begin
          if (ena) begin
            if (timer == TMO_LAST) begin
              state       <= S_ABORT;
              err         <= 1'b1;
              ser_rst_n   <= 1'b0;
              ser_counter <= '0;
              timer       <= '0;
            end else if (ser_flag) begin
              timer <= timer + 1'b1;
              if (len != '1) begin
                len <= len + 1'b1;
              end
            end else begin
              state       <= S_ACK;
              ack         <= N_REQ'(1) << grant_id;
              err         <= (len != LEN_FULL);
              ser_counter <= '0;
              timer       <= '0;
            end
          end
        end

        // Ack (and any length error) is visible this cycle; return to arbitration next.
        S_ACK: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        // Err pulse and serializer reset are visible this cycle; no ack is given.
        S_ABORT: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          ser_rst_n <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
